// File: rtl/multiplexor_display.sv
// -----------------------------------------------------------------------------
// multiplexor_display
//   Scan controller for a 4-digit common-anode seven-segment display. A shadow
//   copy of a 16-bit value is shown one hex nibble at a time. Each digit is lit
//   for CLK_DIV cycles. Optional leading-zero blanking is applied through the
//   anodes only.
//
//   Ports
//     clk          in   system clock, rising edge
//     rst_n        in   synchronous reset, active-low
//     valor        in   value to display (nibble k -> digit k, digit 0 rightmost)
//     cargar       in   load strobe, copies valor into the shadow register
//     blank_ceros  in   leading-zero blanking enable
//     numero       out  nibble of the selected digit, sent to the encoder
//     codifica     in   active-low segment pattern returned by the encoder
//     segmentos    out  registered segment drive, active-low {g,f,e,d,c,b,a}
//     anodos       out  registered anode drive, active-low, at most one low
//     fin_barrido  out  one-cycle pulse when a full 4-digit scan completes
//
// Codificadorsietesegmentos
//   Combinational hex to seven-segment encoder, active-low {g,f,e,d,c,b,a}.
//     numero    in   hex digit
//     codifica  out  segment pattern
// -----------------------------------------------------------------------------
module multiplexor_display #(
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned DIV_W   = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [15:0] valor,
  input  logic       cargar,
  input  logic       blank_ceros,
  output logic [3:0] numero,
  input  logic [6:0] codifica,
  output logic [6:0] segmentos,
  output logic [3:0] anodos,
  output logic       fin_barrido
);

  localparam logic [DIV_W-1:0] PRES_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] PRES_ONE  = DIV_W'(1);

  logic [15:0]      sombra_q, sombra_d;
  logic [DIV_W-1:0] pres_q, pres_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             fin_q, fin_d;
  logic             tick;
  logic             apagado;

  assign tick   = (pres_q == PRES_LAST);
  assign numero = sombra_q[{idx_q, 2'b00} +: 4];

  // A digit is blanked when it and every more significant nibble are zero.
  // Digit 0 is always lit so that a zero value still shows one "0".
  always_comb begin
    apagado = 1'b0;
    case (idx_q)
      2'd1:    apagado = blank_ceros && (sombra_q[15:4]  == 12'h000);
      2'd2:    apagado = blank_ceros && (sombra_q[15:8]  == 8'h00);
      2'd3:    apagado = blank_ceros && (sombra_q[15:12] == 4'h0);
      default: apagado = 1'b0;
    endcase
  end

  always_comb begin
    pres_d   = tick ? '0 : (pres_q + PRES_ONE);
    idx_d    = tick ? (idx_q + 2'd1) : idx_q;
    sombra_d = cargar ? valor : sombra_q;
    fin_d    = tick && (idx_q == 2'd3);
    // Outputs follow the index with one cycle of latency. The segment
    // register always tracks the encoder; blanking is done by the anodes.
    seg_d    = codifica;
    an_d     = apagado ? 4'hF : ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sombra_q <= '0;
      pres_q   <= '0;
      idx_q    <= '0;
      seg_q    <= 7'h7F;
      an_q     <= 4'hF;
      fin_q    <= 1'b0;
    end else begin
      sombra_q <= sombra_d;
      pres_q   <= pres_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      fin_q    <= fin_d;
    end
  end

  assign segmentos   = seg_q;
  assign anodos      = an_q;
  assign fin_barrido = fin_q;

endmodule

module Codificadorsietesegmentos (
  input  logic [3:0] numero,
  output logic [6:0] codifica
);

  always_comb begin
    codifica = 7'h7F;
    case (numero)
      4'h0: codifica = 7'h40;
      4'h1: codifica = 7'h79;
      4'h2: codifica = 7'h24;
      4'h3: codifica = 7'h30;
      4'h4: codifica = 7'h19;
      4'h5: codifica = 7'h12;
      4'h6: codifica = 7'h02;
      4'h7: codifica = 7'h78;
      4'h8: codifica = 7'h00;
      4'h9: codifica = 7'h10;
      4'hA: codifica = 7'h08;
      4'hB: codifica = 7'h03;
      4'hC: codifica = 7'h46;
      4'hD: codifica = 7'h21;
      4'hE: codifica = 7'h06;
      4'hF: codifica = 7'h0E;
      default: codifica = 7'h7F;
    endcase
  end

endmodule

// File: tb/tb_multiplexor_display.sv
module tb_multiplexor_display;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] valor = '0;
  logic        cargar = 1'b0;
  logic        blank_ceros = 1'b0;
  logic [3:0]  numero;
  logic [6:0]  codifica;
  logic [6:0]  segmentos;
  logic [3:0]  anodos;
  logic        fin_barrido;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiplexor_display #(.CLK_DIV(DIV), .DIV_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .valor(valor), .cargar(cargar),
    .blank_ceros(blank_ceros), .numero(numero), .codifica(codifica),
    .segmentos(segmentos), .anodos(anodos), .fin_barrido(fin_barrido)
  );

  Codificadorsietesegmentos enc (.numero(numero), .codifica(codifica));

  // Lit segments (active-high gfedcba) for each hex digit.
  logic [6:0] lit_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: n counts clock edges since reset release; the digit
  // shown is derived from n by arithmetic on the scan period.
  int          n = 0;
  logic [15:0] m_sh = '0;
  logic [15:0] p_sh = '0;
  int          p_idx = 0;
  bit          p_valid = 0;
  bit          p_blank = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0; m_sh = '0; p_valid = 0;
    end else begin
      p_valid = 1;
      p_idx   = (n / DIV) % 4;
      p_sh    = m_sh;
      p_blank = blank_ceros;
      if (cargar) m_sh = valor;
      n = n + 1;
    end
  end

  function automatic logic [3:0] exp_numero();
    logic [15:0] s;
    s = m_sh >> (4 * ((n / DIV) % 4));
    return s[3:0];
  endfunction

  function automatic logic [6:0] exp_seg();
    logic [15:0] s;
    logic [6:0] lit;
    if (!p_valid) return 7'h7F;
    s = p_sh >> (4 * p_idx);
    lit = lit_tbl[s[3:0]];
    return ~lit;
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] one;
    if (!p_valid) return 4'hF;
    if (p_blank && p_idx != 0 && (p_sh >> (4 * p_idx)) == 16'h0) return 4'hF;
    one = 4'b0001 << p_idx;
    return ~one;
  endfunction

  function automatic logic exp_fin();
    return (n > 0) && (n % (4 * DIV) == 0);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      valor = 16'($urandom); cargar = 1'($urandom); blank_ceros = 1'($urandom);
      @(negedge clk);
    end
    checks++; if (anodos !== 4'hF) begin errors++; $display("FAIL reset_anodos got %h exp f", anodos); end
    checks++; if (segmentos !== 7'h7F) begin errors++; $display("FAIL reset_segmentos got %h exp 7f", segmentos); end
    checks++; if (numero !== 4'h0) begin errors++; $display("FAIL reset_numero got %h exp 0", numero); end
    checks++; if (fin_barrido !== 1'b0) begin errors++; $display("FAIL reset_fin got %b exp 0", fin_barrido); end
  endtask

  task automatic test_scan();
    int fins = 0;
    rst_n = 1'b1; valor = 16'h1234; cargar = 1'b1; blank_ceros = 1'b0;
    @(negedge clk);
    cargar = 1'b0; valor = 16'($urandom);
    checks++; if (numero !== 4'h4) begin errors++; $display("FAIL scan_first_numero got %h exp 4", numero); end
    for (int c = 0; c < 48; c++) begin
      checks++; if (numero !== exp_numero()) begin errors++; $display("FAIL scan_numero n=%0d got %h exp %h", n, numero, exp_numero()); end
      checks++; if (anodos !== exp_an()) begin errors++; $display("FAIL scan_anodos n=%0d got %b exp %b", n, anodos, exp_an()); end
      checks++; if (segmentos !== exp_seg()) begin errors++; $display("FAIL scan_segmentos n=%0d got %h exp %h", n, segmentos, exp_seg()); end
      checks++; if (fin_barrido !== exp_fin()) begin errors++; $display("FAIL scan_fin n=%0d got %b exp %b", n, fin_barrido, exp_fin()); end
      if (fin_barrido === 1'b1) fins++;
      @(negedge clk);
    end
    checks++; if (fins != 3) begin errors++; $display("FAIL scan_fin_count got %0d exp 3", fins); end
  endtask

  task automatic test_blanking();
    logic [15:0] vals [3] = '{16'h0042, 16'h0000, 16'h0400};
    for (int v = 0; v < 3; v++) begin
      valor = vals[v]; cargar = 1'b1; blank_ceros = 1'b1;
      @(negedge clk);
      cargar = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 4 * DIV; c++) begin
        checks++; if (anodos !== exp_an()) begin errors++; $display("FAIL blank_anodos v=%h n=%0d got %b exp %b", vals[v], n, anodos, exp_an()); end
        checks++; if (segmentos !== exp_seg()) begin errors++; $display("FAIL blank_segmentos v=%h n=%0d got %h exp %h", vals[v], n, segmentos, exp_seg()); end
        if (v == 0 && p_idx >= 2) begin
          checks++; if (anodos !== 4'hF) begin errors++; $display("FAIL blank_0042_hi got %b exp 1111", anodos); end
        end
        if (v == 1) begin
          checks++; if (anodos !== 4'hF && anodos !== 4'b1110) begin errors++; $display("FAIL blank_0000 got %b exp 1111 or 1110", anodos); end
        end
        if (v == 2 && p_idx == 1) begin
          checks++; if (anodos !== 4'b1101 || segmentos !== 7'h40) begin errors++; $display("FAIL blank_0400_d1 got %b/%h exp 1101/40", anodos, segmentos); end
        end
        @(negedge clk);
      end
    end
    blank_ceros = 1'b0;
  endtask

  task automatic test_load_tick();
    int k;
    valor = 16'h1234; cargar = 1'b1;
    @(negedge clk);
    cargar = 1'b0;
    for (k = 0; k < 40 && (n % (4 * DIV)) != DIV - 1; k++) @(negedge clk);
    checks++; if ((n % (4 * DIV)) != DIV - 1) begin errors++; $display("FAIL load_tick_wait timed out n=%0d", n); end
    valor = 16'hABCD; cargar = 1'b1;
    @(negedge clk);
    cargar = 1'b0;
    checks++; if (numero !== 4'hC) begin errors++; $display("FAIL load_tick_numero got %h exp c", numero); end
    for (int c = 0; c < 20; c++) begin
      checks++; if (numero < 4'hA || numero !== exp_numero()) begin errors++; $display("FAIL load_tick_follow n=%0d got %h exp %h", n, numero, exp_numero()); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    for (k = 0; k < 40 && (n % (4 * DIV)) != 2 * DIV + 1; k++) @(negedge clk);
    checks++; if ((n % (4 * DIV)) != 2 * DIV + 1) begin errors++; $display("FAIL rst_mid_wait timed out n=%0d", n); end
    checks++; if (anodos !== 4'b1011) begin errors++; $display("FAIL rst_mid_pre_anodos got %b exp 1011", anodos); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (anodos !== 4'hF || segmentos !== 7'h7F || numero !== 4'h0 || fin_barrido !== 1'b0) begin
      errors++; $display("FAIL rst_mid_values got %b %h %h %b exp 1111 7f 0 0", anodos, segmentos, numero, fin_barrido); end
    rst_n = 1'b1;
    for (int c = 0; c < DIV; c++) begin
      @(negedge clk);
      checks++; if (anodos !== 4'b1110) begin errors++; $display("FAIL rst_mid_hold c=%0d got %b exp 1110", c, anodos); end
    end
    @(negedge clk);
    checks++; if (anodos !== 4'b1101) begin errors++; $display("FAIL rst_mid_next got %b exp 1101", anodos); end
  endtask

  task automatic test_nibbles();
    for (int x = 0; x < 16; x++) begin
      logic [3:0] nx;
      logic [6:0] want;
      nx = 4'(x);
      want = ~lit_tbl[x];
      valor = {nx, nx, nx, nx}; cargar = 1'b1; blank_ceros = 1'($urandom);
      @(negedge clk);
      cargar = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 4 * DIV; c++) begin
        checks++; if (segmentos !== want) begin errors++; $display("FAIL nibble_seg x=%h got %h exp %h", nx, segmentos, want); end
        checks++; if (anodos !== exp_an()) begin errors++; $display("FAIL nibble_anodos x=%h got %b exp %b", nx, anodos, exp_an()); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      cargar = ($urandom_range(0, 9) == 0);
      valor = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      blank_ceros = 1'($urandom);
      @(negedge clk);
      checks++; if (numero !== exp_numero()) begin errors++; $display("FAIL rand_numero n=%0d got %h exp %h", n, numero, exp_numero()); end
      checks++; if (anodos !== exp_an()) begin errors++; $display("FAIL rand_anodos n=%0d got %b exp %b", n, anodos, exp_an()); end
      checks++; if (segmentos !== exp_seg()) begin errors++; $display("FAIL rand_segmentos n=%0d got %h exp %h", n, segmentos, exp_seg()); end
      checks++; if (fin_barrido !== exp_fin()) begin errors++; $display("FAIL rand_fin n=%0d got %b exp %b", n, fin_barrido, exp_fin()); end
      checks++; if ($countones(~anodos) > 1) begin errors++; $display("FAIL rand_onehot got %b exp at most one low", anodos); end
    end
    rst_n = 1'b1; cargar = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_load_tick();
    test_reset_mid();
    test_nibbles();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
